dmem_arbiter: RTL

//  Shares the single-port data RAM behind the MEM stage between the pipeline and an

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the MEM-stage CPU port owns the RAM by default, and the external port gets single-cycle slots through a 4-phase req/ack handshake.
// Define DMEM_ARB_STARVE_GUARD_EN to enable the bounded-wait starvation guard for the external port.
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  // state  | meaning
  // S_IDLE | CPU owns the RAM; external request may be pending
  // S_EXT  | external port owns the RAM for one cycle; a CPU access stalls
  // S_ACK  | CPU owns the RAM; ext_ack held until ext_req drops

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   guard_fire;

  if (CNT_W < $clog2(MAX_WAIT + 1)) begin : g_bad_cnt_w
    $error("dmem_arbiter: CNT_W too narrow for MAX_WAIT");
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] wait_cnt;

  assign guard_fire = ext_req && (wait_cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state_q == S_IDLE && state_d == S_EXT) begin
      wait_cnt <= '0;
    end else if (state_q == S_IDLE && ext_req && cpu_req &&
                 wait_cnt != CNT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if ((ext_req && !cpu_req) || guard_fire) state_d = S_EXT;
      S_EXT:  state_d = S_ACK;
      S_ACK:  if (!ext_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ram_we is gated by resetn so that an in-flight external write is dropped
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_req && cpu_we && resetn;
    cpu_stall = 1'b0;
    if (state_q == S_EXT) begin
      ram_addr  = ext_addr;
      ram_wdata = ext_wdata;
      ram_we    = ext_we && resetn;
      cpu_stall = cpu_req;
    end
  end

  assign cpu_rdata = ram_rdata;
  assign ext_ack   = (state_q == S_ACK);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ext_rdata <= '0;
    end else if (state_q == S_EXT) begin
      ext_rdata <= ram_rdata;
    end
  end

endmodule
